// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencing controller for a WIDTH-bit parallel-in/serial-out
// shift register. Words arrive through a valid/ready handshake. Each word is
// shifted out over a programmable number of bits, either MSB-first or
// LSB-first. Frames are marked with sof/eof and followed by a done pulse and
// an optional idle gap.
module shift_seq_ctrl #(
   parameter int WIDTH   = 4,
   parameter int CNT_W   = 3,
   parameter int GAP_CYC = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic [CNT_W-1:0] len,
   input  logic             msb_first,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy,
   output logic             done
);

   localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
   logic               firstBit_q, firstBit_d;
   logic               msbFirst_q, msbFirst_d;
   logic               done_q, done_d;

   logic [CNT_W-1:0]   lenClamped;
   logic [WIDTH-1:0]   loadWord;
   logic               inShift;
   logic               lastBit;

   // A zero or oversized length means "shift the full word". For MSB-first
   // frames the word is pre-aligned so that din[L-1] sits at the output end.
   always_comb begin
      lenClamped = len;
      if ((len == '0) || (len > WIDTH_C)) begin
         lenClamped = WIDTH_C;
      end
      loadWord = din;
      if (msb_first) begin
         loadWord = din << (WIDTH_C - lenClamped);
      end
   end

   assign inShift = (state_q == SHIFT);
   assign lastBit = (count_q == ONE_C);

   // Next-state logic: the accept in IDLE, the per-bit shift/count in SHIFT,
   // and the fixed-length idle gap in GAP. done is raised only on the edge
   // that consumes the final bit, so it is a one-cycle pulse.
   always_comb begin
      state_d    = state_q;
      shiftReg_d = shiftReg_q;
      count_d    = count_q;
      gapCnt_d   = gapCnt_q;
      firstBit_d = firstBit_q;
      msbFirst_d = msbFirst_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (din_valid) begin
               shiftReg_d = loadWord;
               count_d    = lenClamped;
               msbFirst_d = msb_first;
               firstBit_d = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               shiftReg_d = msbFirst_q ? (shiftReg_q << 1) : (shiftReg_q >> 1);
               count_d    = count_q - ONE_C;
               firstBit_d = 1'b0;
               if (lastBit) begin
                  done_d = 1'b1;
                  if (GAP_CYC > 0) begin
                     state_d  = GAP;
                     gapCnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         GAP: begin
            if (gapCnt_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gapCnt_d = gapCnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; clr wins over everything and drops any frame in flight.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= IDLE;
         shiftReg_q <= '0;
         count_q    <= '0;
         gapCnt_q   <= '0;
         firstBit_q <= 1'b0;
         msbFirst_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shiftReg_q <= shiftReg_d;
         count_q    <= count_d;
         gapCnt_q   <= gapCnt_d;
         firstBit_q <= firstBit_d;
         msbFirst_q <= msbFirst_d;
         done_q     <= done_d;
      end
   end

   // Outputs are decoded from registered state and are all forced low while
   // clr is asserted. This keeps them quiet before the first reset edge.
   assign din_ready  = !clr && (state_q == IDLE);
   assign busy       = !clr && (state_q != IDLE);
   assign sout_valid = !clr && inShift && shift_en;
   assign sout       = !clr && inShift && (msbFirst_q ? shiftReg_q[WIDTH-1] : shiftReg_q[0]);
   assign sof        = !clr && inShift && firstBit_q;
   assign eof        = !clr && inShift && lastBit;
   assign done       = !clr && done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed bench for shift_seq_ctrl (WIDTH=4, CNT_W=3,
// GAP_CYC=1) with hand-computed per-cycle expectations.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       clr;
   logic [3:0] din;
   logic       din_valid;
   logic       din_ready;
   logic [2:0] len;
   logic       msb_first;
   logic       shift_en;
   logic       sout;
   logic       sout_valid;
   logic       sof;
   logic       eof;
   logic       busy;
   logic       done;

   int assertCount  = 0;
   int failureCount = 0;

   shift_seq_ctrl #(
      .WIDTH  (4),
      .CNT_W  (3),
      .GAP_CYC(1)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .len       (len),
      .msb_first (msb_first),
      .shift_en  (shift_en),
      .sout      (sout),
      .sout_valid(sout_valid),
      .sof       (sof),
      .eof       (eof),
      .busy      (busy),
      .done      (done)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Drives every DUT input for the coming edge
   task automatic applyStimulus(input logic c, input logic v, input logic [3:0] d,
                                input logic [2:0] l, input logic m, input logic e);
      clr       = c;
      din_valid = v;
      din       = d;
      len       = l;
      msb_first = m;
      shift_en  = e;
   endtask

   // One comparison with failure accounting
   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      assertCount++;
      assert (observed === expected) else begin
         failureCount++;
         $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
         $error("[TB] check %s", tag);
      end
   endtask

   // Checks all outputs for the current cycle; an x for sout means unspecified
   task automatic checkCycle(input string tag, input logic vld, input logic so,
                             input logic sf, input logic ef, input logic dn,
                             input logic rdy, input logic bsy);
      #1;
      checkOutput({tag, ".sout_valid"}, sout_valid, vld);
      if (so !== 1'bx) checkOutput({tag, ".sout"}, sout, so);
      checkOutput({tag, ".sof"},       sof,       sf);
      checkOutput({tag, ".eof"},       eof,       ef);
      checkOutput({tag, ".done"},      done,      dn);
      checkOutput({tag, ".din_ready"}, din_ready, rdy);
      checkOutput({tag, ".busy"},      busy,      bsy);
   endtask

   // Advance to just after the next rising edge
   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   // Directed scenario sequence
   initial begin
      // Reset held two cycles with a word offered
      applyStimulus(1, 1, 4'b1011, 3'd4, 1, 1);
      checkCycle("rst0", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      checkCycle("rst1", 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(0, 1, 4'b1011, 3'd4, 1, 1);
      checkCycle("idle0", 0, 1'bx, 0, 0, 0, 1, 0);

      // MSB-first 1011, len 4
      nextCycle();
      applyStimulus(0, 0, 4'b1011, 3'd4, 1, 1);
      checkCycle("msb1", 1, 1, 1, 0, 0, 0, 1);
      nextCycle();
      checkCycle("msb2", 1, 0, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("msb3", 1, 1, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("msb4", 1, 1, 0, 1, 0, 0, 1);
      nextCycle();
      checkCycle("msbDone", 0, 1'bx, 0, 0, 1, 0, 1);
      nextCycle();
      applyStimulus(0, 1, 4'b0110, 3'd3, 0, 1);
      checkCycle("msbReady", 0, 1'bx, 0, 0, 0, 1, 0);

      // LSB-first 0110, len 3
      nextCycle();
      applyStimulus(0, 0, 4'b0110, 3'd3, 0, 1);
      checkCycle("lsb1", 1, 0, 1, 0, 0, 0, 1);
      nextCycle();
      checkCycle("lsb2", 1, 1, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("lsb3", 1, 1, 0, 1, 0, 0, 1);
      nextCycle();
      checkCycle("lsbDone", 0, 1'bx, 0, 0, 1, 0, 1);
      nextCycle();
      applyStimulus(0, 1, 4'b1011, 3'd4, 1, 1);
      checkCycle("lsbReady", 0, 1'bx, 0, 0, 0, 1, 0);

      // MSB-first 1011 with a one-cycle stall on the second bit
      nextCycle();
      applyStimulus(0, 0, 4'b1011, 3'd4, 1, 1);
      checkCycle("stall1", 1, 1, 1, 0, 0, 0, 1);
      nextCycle();
      applyStimulus(0, 0, 4'b1011, 3'd4, 1, 0);
      checkCycle("stall2", 0, 0, 0, 0, 0, 0, 1);
      nextCycle();
      applyStimulus(0, 0, 4'b1011, 3'd4, 1, 1);
      checkCycle("stall3", 1, 0, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("stall4", 1, 1, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("stall5", 1, 1, 0, 1, 0, 0, 1);
      nextCycle();
      checkCycle("stallDone", 0, 1'bx, 0, 0, 1, 0, 1);
      nextCycle();
      applyStimulus(0, 1, 4'b1011, 3'd4, 1, 1);
      checkCycle("stallReady", 0, 1'bx, 0, 0, 0, 1, 0);

      // Reset after two bits of a frame
      nextCycle();
      applyStimulus(0, 0, 4'b1011, 3'd4, 1, 1);
      checkCycle("midRst1", 1, 1, 1, 0, 0, 0, 1);
      nextCycle();
      checkCycle("midRst2", 1, 0, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 4'b1011, 3'd4, 1, 1);
      nextCycle();
      applyStimulus(0, 1, 4'b1011, 3'd0, 1, 1);
      checkCycle("midRst3", 0, 1'bx, 0, 0, 0, 1, 0);

      // len 0 clamps to 4; len 7 follows back-to-back with din_valid held
      nextCycle();
      applyStimulus(0, 1, 4'b0110, 3'd7, 1, 1);
      checkCycle("clampA1", 1, 1, 1, 0, 0, 0, 1);
      nextCycle();
      checkCycle("clampA2", 1, 0, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("clampA3", 1, 1, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("clampA4", 1, 1, 0, 1, 0, 0, 1);
      nextCycle();
      checkCycle("clampADone", 0, 1'bx, 0, 0, 1, 0, 1);
      nextCycle();
      checkCycle("clampAReady", 0, 1'bx, 0, 0, 0, 1, 0);
      nextCycle();
      applyStimulus(0, 0, 4'b0110, 3'd7, 1, 1);
      checkCycle("clampB1", 1, 0, 1, 0, 0, 0, 1);
      nextCycle();
      checkCycle("clampB2", 1, 1, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("clampB3", 1, 1, 0, 0, 0, 0, 1);
      nextCycle();
      checkCycle("clampB4", 1, 0, 0, 1, 0, 0, 1);
      nextCycle();
      checkCycle("clampBDone", 0, 1'bx, 0, 0, 1, 0, 1);
      nextCycle();
      checkCycle("clampBReady", 0, 1'bx, 0, 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
      $finish;
   end

endmodule
